uart_rx_core: RTL and testbench

//  Standalone UART receiver: mid-bit sampling of the asynchronous rx line, 8N1 frames
//  (optional even parity), LSB first. Delivers each byte as a one-cycle valid pulse.

---
 rtl/uart_rx_core.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: standalone UART receiver.
//   Samples the asynchronous rx line at mid-bit and receives LSB-first frames:
//   start, DATA_BITS data bits, an optional even-parity bit, and one stop bit.
//   Each good byte is delivered with a one-cycle rx_valid pulse.
// Configuration macro: UART_PARITY_EN
//   Defined: a parity bit follows the data bits and even parity is checked.
//   Undefined: there is no parity bit, and parity_err is tied low.
// Ports:
//   clk        system clock; all logic runs on posedge
//   rst        asynchronous active-high reset
//   rx         serial line; idles high; asynchronous to clk
//   rx_data    last good byte; held until the next good byte arrives
//   rx_valid   one-cycle pulse when rx_data is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   parity_err one-cycle pulse, together with rx_valid, on a parity mismatch
//   busy       high whenever the receiver is not idle
module uart_rx_core #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    // Two-flop synchroniser plus one delay stage, used for falling-edge detection.
    logic sync_q, rx_s_q, rx_dly_q;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_dly_q && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    shift_d[DATA_BITS-1] = rx_s_q;
                    for (int i = 0; i < int'(DATA_BITS) - 1; i++) begin
                        shift_d[i] = shift_q[i+1];
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = (^shift_q) ^ rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_PARITY_EN
                        perr_d  = par_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_dly_q <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            sync_q   <= rx;
            rx_s_q   <= sync_q;
            rx_dly_q <= rx_s_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
`ifdef UART_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized and directed bench for uart_rx_core.
//   A frame-level model recorded in the bench finds each line falling edge in the
//   sampled rx history and reads the line at the scheduled mid-bit points. It then
//   predicts every DUT output for every cycle. Directed scenarios pin the model
//   with literal expectations.
module tb_uart_rx_core;

    localparam int CLKS = 10;
    localparam int HALF = 5;
    localparam int DB   = 8;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME_CYC = CLKS * (DB + 2 + PB);
    localparam int HIST_MAX  = 65536;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    uart_rx_core #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .DATA_BITS(DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         hist [HIST_MAX];
    int         n = 0;
    bit         m_active = 0;
    int         m_f = 0;
    int         m_min_f = 0;
    logic [7:0] m_shift = '0;
    logic [7:0] m_data = '0;
    bit         m_par = 0;
    bit         e_valid = 0, e_ferr = 0, e_perr = 0, e_busy = 0;

    // Edge n's outputs reflect what the model decides about line index n-2. That is
    // the synchroniser delay between sampling rx and the receiver reacting to it.
    initial begin
        int j, off, k;
        forever begin
            @(posedge clk);
            n++;
            if (n >= HIST_MAX) begin
                $display("FAIL history_overflow: got %0d, expected < %0d", n, HIST_MAX);
                $fatal(1, "history overflow");
            end
            e_valid = 0;
            e_ferr  = 0;
            e_perr  = 0;
            if (rst) begin
                hist[n]  = 1'b1;
                m_active = 0;
                m_data   = '0;
                m_min_f  = n + 1;
                e_busy   = 0;
            end else begin
                hist[n] = rx;
                j = n - 2;
                if (!m_active && j >= m_min_f && j >= 1 && hist[j-1] && !hist[j]) begin
                    m_active = 1;
                    m_f      = j;
                    m_par    = 0;
                end
                e_busy = m_active;
                if (m_active) begin
                    off = j - m_f - HALF;
                    if (off >= 0 && (off % CLKS) == 0) begin
                        k = off / CLKS;
                        if (k == 0) begin
                            if (hist[j]) begin
                                m_active = 0;
                                e_busy   = 0;
                                m_min_f  = j + 1;
                            end
                        end else if (k <= DB) begin
                            m_shift[k-1] = hist[j];
                        end else if (PB == 1 && k == DB + 1) begin
                            m_par = (^m_shift) ^ hist[j];
                        end else begin
                            if (hist[j]) begin
                                m_data  = m_shift;
                                e_valid = 1;
                                e_perr  = m_par;
                            end else begin
                                e_ferr = 1;
                            end
                            m_active = 0;
                            e_busy   = 0;
                            m_min_f  = j + 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    logic [7:0] got_data[$];
    int         got_edge[$];
    bit         got_perr[$];
    int         ferr_cnt = 0;
    int         busy_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (n >= 1) begin
                check("rx_valid", rx_valid, e_valid);
                check("frame_err", frame_err, e_ferr);
                check("parity_err", parity_err, e_perr);
                check("busy", busy, e_busy);
                check("rx_data", rx_data, m_data);
                if (rx_valid) begin
                    got_data.push_back(rx_data);
                    got_edge.push_back(n);
                    got_perr.push_back(parity_err);
                end
                if (frame_err) ferr_cnt++;
                if (busy) busy_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic b, input int cyc);
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            #1 rx = b;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        drive(1'b0, CLKS);
        for (int i = 0; i < DB; i++) drive(d[i], CLKS);
        if (PB == 1) drive(par, CLKS);
        drive(stop, CLKS);
    endtask

    task automatic clear_logs();
        got_data.delete();
        got_edge.delete();
        got_perr.delete();
        ferr_cnt = 0;
        busy_cnt = 0;
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 5);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        drive(1'b1, 20);

        // Single frame 0x41.
        clear_logs();
        send(8'h41, 1'b1, ^8'h41);
        drive(1'b1, 20);
        check("t1_count", got_data.size(), 1);
        if (got_data.size() > 0) check("t1_data", got_data[0], 8'h41);
        check("t1_model", m_data, 8'h41);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_busy", busy, 1'b0);

        // Back-to-back 0x00 then 0xFF.
        clear_logs();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        drive(1'b1, 20);
        check("t2_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("t2_data0", got_data[0], 8'h00);
            check("t2_data1", got_data[1], 8'hFF);
            check("t2_spacing", got_edge[1] - got_edge[0], FRAME_CYC);
        end

        // Three-cycle glitch.
        clear_logs();
        drive(1'b0, 3);
        drive(1'b1, 30);
        check("t3_count", got_data.size(), 0);
        check("t3_ferr", ferr_cnt, 0);
        check("t3_busy_cycles", busy_cnt, 5);

        // Frame error, then a long break.
        clear_logs();
        send(8'h55, 1'b0, ^8'h55);
        drive(1'b0, 30 * CLKS);
        drive(1'b1, 50);
        check("t4_ferr", ferr_cnt, 1);
        check("t4_count", got_data.size(), 0);
        check("t4_hold", rx_data, 8'hFF);
        check("t4_idle", busy, 1'b0);

        // Reset during bit 3 of 0xA5, then a clean 0x3C.
        clear_logs();
        drive(1'b0, CLKS);
        drive(1'b1, CLKS);
        drive(1'b0, CLKS);
        drive(1'b1, CLKS);
        drive(1'b0, 5);
        @(negedge clk);
        #1 begin rst = 1'b1; rx = 1'b1; end
        @(negedge clk);
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", rx_valid, 1'b0);
        #1 rst = 1'b0;
        drive(1'b1, 30);
        send(8'h3C, 1'b1, ^8'h3C);
        drive(1'b1, 20);
        check("t5_count", got_data.size(), 1);
        if (got_data.size() > 0) check("t5_data", got_data[0], 8'h3C);
        check("t5_ferr", ferr_cnt, 0);

`ifdef UART_PARITY_EN
        // 0x07 has three ones: a parity bit of 0 is wrong, and 1 is right.
        clear_logs();
        send(8'h07, 1'b1, 1'b0);
        drive(1'b1, 5);
        send(8'h07, 1'b1, 1'b1);
        drive(1'b1, 20);
        check("t6_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("t6_perr_bad", got_perr[0], 1'b1);
            check("t6_perr_good", got_perr[1], 1'b0);
            check("t6_data", got_data[1], 8'h07);
        end
`endif

        // Randomized traffic: glitches, gaps, bad stop bits and bad parity.
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b0, $urandom_range(1, 4));
                drive(1'b1, $urandom_range(3, 12));
            end
            d = 8'($urandom);
            send(d, ($urandom_range(0, 7) != 0), (^d) ^ ($urandom_range(0, 5) == 0));
            drive(1'b1, $urandom_range(0, 15));
        end
        drive(1'b1, 3 * FRAME_CYC);
        check("end_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
